// File: rtl/uart_tx_mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package uart_tx_mmio_pkg;

    // Register offsets within the 8-byte window
    localparam logic [2:0] uart_txdata_offset = 3'h0;
    localparam logic [2:0] uart_status_offset = 3'h4;

    // STATUS bit positions
    localparam int unsigned status_full     = 0;
    localparam int unsigned status_busy     = 1;
    localparam int unsigned status_empty    = 2;
    localparam int unsigned status_overflow = 3;

    localparam int unsigned bus_w = 32;

    // Serialiser states
    typedef enum logic [1:0] {
        tx_idle,
        tx_start,
        tx_data,
        tx_stop
    } uart_tx_state;

    // STATUS register payload
    typedef struct packed {
        logic overflow;
        logic empty;
        logic busy;
        logic full;
    } uart_status_t;

    // Place the status fields at their bit positions in a bus word
    function automatic logic [bus_w-1:0] pack_status(input uart_status_t s);
        logic [bus_w-1:0] w;
        w = '0;
        w[status_full]     = s.full;
        w[status_busy]     = s.busy;
        w[status_empty]    = s.empty;
        w[status_overflow] = s.overflow;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Single-clock FIFO with a combinational head; pushes while full are dropped.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Fullness and emptiness come straight from the registered count
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA store pushes a FIFO, STATUS is pollable.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0002_0000,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_mask,
    input  logic        write_en,
    input  logic        read_en,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        tx_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic             hit;
    logic [2:0]       offset;
    logic             push_req;
    logic             status_store;
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             overflow;
    uart_status_t     status;
    logic [31:0]      read_data_next;

    uart_tx_state     state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    logic             unused_bus_bits;
    assign unused_bus_bits = ^{write_data[31:8], write_mask[3:1]};

    // Address decode for the 8-byte register window
    assign hit          = (addr[31:3] == BASE_ADDR[31:3]);
    assign offset       = addr[2:0];
    assign push_req     = write_en && hit && (offset == uart_txdata_offset) && write_mask[0];
    assign status_store = write_en && hit && (offset == uart_status_offset);
    assign fifo_pop     = (state == tx_idle) && !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (write_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sticky overflow: set by a push against a full FIFO, cleared by any STATUS store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (status_store) begin
            overflow <= 1'b0;
        end else if (push_req && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // Load data selection from pre-edge state; holds when no load is issued
    always_comb begin
        status.full     = fifo_full;
        status.busy     = tx_busy;
        status.empty    = fifo_empty;
        status.overflow = overflow;
        read_data_next  = read_data;
        if (read_en) begin
            if (hit && (offset == uart_status_offset)) begin
                read_data_next = pack_status(status);
            end else begin
                read_data_next = '0;
            end
        end
    end

    // Registered load data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data <= '0;
        end else begin
            read_data <= read_data_next;
        end
    end

    // 8N1 serialiser; tx and tx_busy are set alongside each state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= tx_idle;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                tx_idle: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        shift    <= fifo_dout;
                        baud_cnt <= CNT_RELOAD;
                        state    <= tx_start;
                        tx       <= 1'b0;
                        tx_busy  <= 1'b1;
                    end
                end
                tx_start: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= CNT_RELOAD;
                        bit_idx  <= '0;
                        state    <= tx_data;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                tx_data: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= CNT_RELOAD;
                        shift    <= shift >> 1;
                        if (bit_idx == 3'd7) begin
                            state <= tx_stop;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                tx_stop: begin
                    if (baud_cnt == '0) begin
                        state   <= tx_idle;
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= tx_idle;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the core's data-memory bus, downstream of the store path.
- The core's address decode routes accesses at uart_address (32'h00020000) here instead of data RAM.
- Stores to TXDATA push a byte into a small FIFO; an 8N1 serialiser drains the FIFO onto the tx pin.
- STATUS is readable so firmware can poll before writing.

Parameters:
- BASE_ADDR, 32'h00020000, register window base; must be 8-byte aligned.
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- addr  in  32  bus byte address.
- write_data  in  32  store data; byte lane 0 is used.
- write_mask  in  4  byte enables (mask_byte/mask_half/mask_word encodings).
- write_en  in  1  store strobe, one cycle per store.
- read_en  in  1  load strobe, one cycle per load.
- read_data  out  32  registered load data.
- tx  out  1  serial output, idle high.
- tx_busy  out  1  serialiser not in IDLE.

Behaviour:
- Decode: hit when addr[31:3] == BASE_ADDR[31:3]. Offset 0x0 is TXDATA (write-only; reads return 0). Offset 0x4 is STATUS. Accesses without a hit are ignored entirely.
- STATUS bits (all other bits read 0):
  - bit0 fifo_full
  - bit1 tx_busy
  - bit2 fifo_empty
  - bit3 overflow (sticky)
- Any store to STATUS clears overflow.
- Push condition: write_en, hit, offset 0x0, write_mask[0] = 1. The pushed byte is write_data[7:0].
- Full handling: fullness is evaluated on pre-edge state.
  - Push while full is dropped and sets overflow, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle with FIFO not full: both happen; count is unchanged.
- Read: read_data is registered and valid the cycle after read_en.
  - Holds its value when read_en is low.
  - Loads 0 on a miss.
  - STATUS reflects pre-edge state.
- Serialiser FSM states: IDLE, START, DATA, STOP. Baud counter counts CLKS_PER_BIT-1 down to 0; a bit ends when the counter is 0.
  - IDLE: tx = 1. If the FIFO is not empty, pop the head into the shift register, load the counter, and go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0]. Shift right at each bit end. After bit index 7 completes, go to STOP. LSB is sent first.
  - STOP: tx = 1 for CLKS_PER_BIT cycles, then go to IDLE.
  - Back-to-back frames have exactly 1 cycle of idle between the stop bit and the next start bit.
- Frame length: START entry to IDLE re-entry is exactly 10*CLKS_PER_BIT cycles.
- tx_busy = (state != IDLE).
- tx is driven from a flop; no combinational glitches.
- Reset (async, any time, including mid-frame):
  - state = IDLE, tx = 1, tx_busy = 0.
  - FIFO empty, pointers = 0, overflow = 0.
  - read_data = 0, counter = 0.
  - A partially sent frame is abandoned; the line returns high immediately.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1, so full and empty are distinguishable.

Decomposition:
- Add to the shared riscv_data package:
  - uart_txdata_offset = 3'h0 and uart_status_offset = 3'h4.
  - Status bit index constants: status_full, status_busy, status_empty, status_overflow.
  - typedef enum uart_tx_state {tx_idle, tx_start, tx_data, tx_stop}.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Ports: push, pop, din, dout, full, empty.
  - dout shows the head combinationally.
  - Reusable later for an RX path.

Test Plan:
- Reset then idle 100 cycles -> tx = 1 throughout; STATUS read returns 32'h4.
- Store 32'h000000A5, mask 4'b0001, to 32'h00020000; CLKS_PER_BIT = 4 -> tx shows 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles. Frame lasts 40 cycles; tx_busy is high for those 40 cycles only.
- Write 3 bytes back-to-back -> three frames in order, each separated by exactly 1 idle-high cycle. fifo_empty is set after the third pop.
- Write 10 bytes with DEPTH = 8 while the serialiser is stalled mid-frame:
  - STATUS reads 32'hB (full, busy, overflow).
  - The dropped bytes never appear on tx.
  - A store to 0x00020004 clears overflow, so STATUS reads 32'h3.
- Edge cases:
  - Store with mask 4'b0000 pushes nothing.
  - Store to 32'h00020008 has no effect.
  - Load of TXDATA returns 0 one cycle after read_en.
- Assert rst during DATA bit 3 -> tx = 1 asynchronously, STATUS reads 32'h4 after release, and the next pushed byte transmits a full clean frame.
